// File: rtl/restoring_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one shift/subtract/restore step per clock,
// quotient and remainder returned with a one-cycle done pulse.
module restoring_divider #(
   parameter int DIV_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_op,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_WIDTH-1:0] quotient,
   output logic [DIV_WIDTH-1:0] remainder,
   output logic                 div_by_zero
);

   localparam int CW = (DIV_WIDTH > 2) ? $clog2(DIV_WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } state_t;

   state_t               state;
   logic [DIV_WIDTH:0]   part_rem;
   logic [DIV_WIDTH-1:0] dvd_reg;
   logic [DIV_WIDTH-1:0] dsr_reg;
   logic [DIV_WIDTH-1:0] orig_dividend;
   logic [CW-1:0]        count;
   logic                 q_neg;
   logic                 r_neg;
   logic                 zero_div;

   logic                 dividend_neg;
   logic                 divisor_neg;
   logic [DIV_WIDTH-1:0] dividend_mag;
   logic [DIV_WIDTH-1:0] divisor_mag;
   logic [DIV_WIDTH+1:0] shifted;
   logic [DIV_WIDTH+1:0] trial;
   logic [DIV_WIDTH-1:0] q_final;
   logic [DIV_WIDTH-1:0] r_final;

   assign dividend_neg = signed_op & dividend[DIV_WIDTH-1];
   assign divisor_neg  = signed_op & divisor[DIV_WIDTH-1];
   assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
   assign divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;

   // Trial is one bit wider than the partial remainder so its MSB is a clean sign bit.
   assign shifted = {part_rem, dvd_reg[DIV_WIDTH-1]};
   assign trial   = shifted - {2'b00, dsr_reg};

   assign q_final = zero_div ? {DIV_WIDTH{1'b1}}
                  : (q_neg ? (~dvd_reg + 1'b1) : dvd_reg);
   assign r_final = zero_div ? orig_dividend
                  : (r_neg ? (~part_rem[DIV_WIDTH-1:0] + 1'b1) : part_rem[DIV_WIDTH-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         part_rem      <= '0;
         dvd_reg       <= '0;
         dsr_reg       <= '0;
         orig_dividend <= '0;
         count         <= '0;
         q_neg         <= 1'b0;
         r_neg         <= 1'b0;
         zero_div      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         quotient      <= '0;
         remainder     <= '0;
         div_by_zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_reg       <= dividend_mag;
                  dsr_reg       <= divisor_mag;
                  orig_dividend <= dividend;
                  q_neg         <= dividend_neg ^ divisor_neg;
                  r_neg         <= dividend_neg;
                  zero_div      <= (divisor == '0);
                  part_rem      <= '0;
                  count         <= '0;
                  busy          <= 1'b1;
                  state         <= CALC;
               end
            end
            CALC: begin
               if (!trial[DIV_WIDTH+1]) begin
                  part_rem <= trial[DIV_WIDTH:0];
                  dvd_reg  <= {dvd_reg[DIV_WIDTH-2:0], 1'b1};
               end else begin
                  part_rem <= shifted[DIV_WIDTH:0];
                  dvd_reg  <= {dvd_reg[DIV_WIDTH-2:0], 1'b0};
               end
               count <= count + CW'(1);
               if (count == CW'(DIV_WIDTH - 1)) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               quotient    <= q_final;
               remainder   <= r_final;
               div_by_zero <= zero_div;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random operands compared
// against a plain-arithmetic division model.
module tb_restoring_divider;

   localparam int W       = 32;
   localparam int LATENCY = W + 1;
   localparam int BOUND   = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         signed_op;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int compared   = 0;
   int mismatched = 0;
   int latency;

   restoring_divider #(.DIV_WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: truncating division, remainder takes the dividend's sign.
   task automatic modelDiv(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      z = (b == '0);
      if (z) begin
         q = '1;
         r = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
      end else if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   task automatic waitDone(input int already);
      latency = already;
      while (!done && latency < BOUND) begin
         @(posedge clk);
         #1;
         latency++;
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      int guard = 0;
      while (busy && guard < BOUND) begin
         @(posedge clk);
         #1;
         guard++;
      end
      @(negedge clk);
      start     = 1'b1;
      signed_op = s;
      dividend  = a;
      divisor   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic s, input logic [W-1:0] a,
                              input logic [W-1:0] b);
      logic [W-1:0] eq, er;
      logic         ez;
      modelDiv(s, a, b, eq, er, ez);
      checkOutput({tag, ".latency"}, W'(latency), W'(LATENCY));
      checkOutput({tag, ".q"}, quotient, eq);
      checkOutput({tag, ".r"}, remainder, er);
      checkOutput({tag, ".dbz"}, W'(div_by_zero), W'(ez));
   endtask

   task automatic runCase(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      applyStimulus(s, a, b);
      checkOutput({tag, ".busy"}, W'(busy), W'(1));
      waitDone(0);
      checkResult(tag, s, a, b);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs;
      int           sawDone;

      rst_n     = 1'b0;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #3;
      checkOutput("reset.busy", W'(busy), W'(0));
      checkOutput("reset.done", W'(done), W'(0));
      checkOutput("reset.q", quotient, '0);
      checkOutput("reset.r", remainder, '0);
      checkOutput("reset.dbz", W'(div_by_zero), W'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      runCase("divu_100_7", 1'b0, 32'd100, 32'd7);
      runCase("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      runCase("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      runCase("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      runCase("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
      runCase("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      runCase("divu_5_9", 1'b0, 32'd5, 32'd9);
      runCase("divu_by0", 1'b0, 32'd1234, 32'd0);
      runCase("div_by0_neg", 1'b1, 32'hFFFF_FF00, 32'd0);
      runCase("divu_10_3", 1'b0, 32'd10, 32'd3);

      // A second start while busy must not disturb the operation in flight.
      applyStimulus(1'b0, 32'd1000, 32'd33);
      repeat (5) @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(6);
      checkResult("ignored_start", 1'b0, 32'd1000, 32'd33);

      // Start held high through done: the next operation is accepted on the following edge.
      applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd9);
      start     = 1'b1;
      signed_op = 1'b0;
      dividend  = 32'd4000;
      divisor   = 32'd7;
      waitDone(0);
      checkResult("held_first", 1'b1, 32'hFFFF_FF9C, 32'd9);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("held_accept.busy", W'(busy), W'(1));
      waitDone(0);
      checkResult("held_second", 1'b0, 32'd4000, 32'd7);

      // Reset in the middle of an operation.
      applyStimulus(1'b0, 32'd999, 32'd4);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.busy", W'(busy), W'(0));
      checkOutput("midrst.done", W'(done), W'(0));
      checkOutput("midrst.q", quotient, '0);
      checkOutput("midrst.r", remainder, '0);
      checkOutput("midrst.dbz", W'(div_by_zero), W'(0));
      @(negedge clk);
      rst_n   = 1'b1;
      sawDone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) sawDone = 1;
      end
      checkOutput("midrst.no_done", W'(sawDone), W'(0));
      runCase("after_rst_50_5", 1'b0, 32'd50, 32'd5);

      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 4))
            0: rb = '0;
            1: rb = W'($urandom_range(1, 15));
            2: ra = 32'h8000_0000;
            3: rb = W'(-$signed(W'($urandom_range(1, 15))));
            default: ;
         endcase
         runCase($sformatf("rand%0d", i), rs, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
